maze_dfs_engine: RTL and testbench
==================================

Name: maze_dfs_engine

Overview:
- Self-contained depth-first maze walker: integrated controller, parametrised coordinate width and direction-stack depth.
- Explores a 2^N x 2^N grid from (0,0) to goal (2^N-1, 2^N-1).
- Cell occupancy comes from an external maze memory over a req/valid handshake.
- The solved path is retained and read out move-by-move. Sits between the maze RAM and the result consumer; replaces the fixed 4-bit datapath + external controller pair.

Parameters:
- N, 4: coordinate width; grid is 2^N x 2^N.
- DEPTH, 256: direction stack / path capacity in moves.
- AW, $clog2(DEPTH): stack pointer width (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begin solve; sampled in IDLE/DONE/FAIL only.
- mem_rd  out  1  cell probe request.
- mem_addr  out  2N  probed cell {Y,X}.
- mem_valid  in  1  probe response valid.
- mem_wall  in  1  1 = probed cell blocked; qualified by mem_valid.
- X  out  N  current column.
- Y  out  N  current row.
- busy  out  1  solve in progress.
- done  out  1  goal reached; level until next start or reset.
- fail  out  1  no path or stack overflow; level until next start or reset.
- path_len  out  AW+1  number of moves in solved path.
- rd_en  in  1  advance readout pointer.
- move  out  2  current readout move.
- move_valid  out  1  move holds a valid path entry.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; stack pointer, readout pointer and visited bitmap cleared.
- Direction encoding: 0 = X+1, 1 = Y+1, 2 = X-1, 3 = Y-1. Reverse of d is d^2.
- FSM states: IDLE, INIT, PROBE, WAIT, MOVE, NEXT, BACK, DONE, FAIL.
- IDLE/DONE/FAIL, start=1 -> INIT next cycle. start in any other state is ignored.
- INIT (1 cycle):
  - X=Y=0; sp=0; readout pointer=0; dir=0.
  - Visited bitmap (2^(2N) bits) cleared, cell (0,0) marked visited; done=fail=0; busy=1.
  - -> PROBE.
- PROBE:
  - Compute neighbour in direction dir.
  - Out of grid (carry/borrow out of N bits) or visited -> NEXT, no memory access.
  - Otherwise -> WAIT.
- WAIT:
  - mem_rd=1 with mem_addr stable until the cycle mem_valid=1 is sampled.
  - mem_valid while mem_rd=0 is ignored.
  - mem_wall=1 -> NEXT; mem_wall=0 -> MOVE.
- MOVE:
  - If sp==DEPTH -> FAIL (overflow).
  - Else push dir, sp+1; X/Y step to neighbour; mark visited; dir=0.
  - New position == goal -> DONE; else -> PROBE.
- NEXT: dir==3 -> BACK; else dir+1 -> PROBE.
- BACK:
  - sp==0 -> FAIL.
  - Else pop d, sp-1; step X/Y by reverse(d).
  - d==3 -> stay in BACK (next cycle pops again); else dir=d+1 -> PROBE.
- DONE:
  - busy=0; done=1; path_len=sp; stack contents preserved.
  - move = stack[rdptr]; move_valid = (rdptr < path_len).
  - rd_en with move_valid -> rdptr+1.
  - rd_en while move_valid=0 has no effect.
- FAIL: busy=0; fail=1; path_len=0; move_valid=0; X/Y hold last position.
- Reset mid-operation (any state, including WAIT with mem_rd high): immediate return to reset values; no pending probe survives.
- The start cell is never probed; it is open by definition.

Optional Feature:
- Macro MAZE_STEP_COUNT_EN.
- Defined:
  - Adds output step_count [15:0], cleared in INIT.
  - Increments by 1 on every MOVE push and every BACK pop; saturates at 16'hFFFF.
  - Holds its value in DONE/FAIL; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Open maze, N=2, mem_wall=0, mem_valid 1 cycle after mem_rd:
  - done=1, X=Y=3, path_len=6.
  - Readout 0,0,0,1,1,1, then move_valid=0.
- Backtrack, N=2, walls only at (3,1):
  - Dead end at (3,0) causes one pop.
  - done=1, path_len=6, readout 0,0,1,1,0,1.
- Unreachable, N=2, walls at (1,0) and (0,1):
  - fail=1, done=0, path_len=0, X=Y=0, move_valid=0.
- Latency, open maze with mem_valid delayed 3 cycles per probe:
  - mem_rd high 4 cycles per probe with mem_addr stable.
  - Final result identical to scenario 1.
- Reset and overflow:
  - Assert RST during WAIT: all outputs 0 next sample; a fresh start then solves the open maze.
  - DEPTH=4, open N=2 maze: fail=1 on 5th push attempt.
- MAZE_STEP_COUNT_EN defined:
  - Scenario 2 ends with step_count=8 (7 pushes + 1 pop).
  - Scenario 1 ends with step_count=6.

Source files
------------

// File: rtl/maze_dfs_engine.sv
// maze_dfs_engine: depth-first maze walker over a 2^N x 2^N grid.
// Starts at (0,0), searches for (2^N-1, 2^N-1), probing cell occupancy in an
// external maze memory. The solved path is kept on the direction stack and
// can be read out move-by-move once DONE.
//
// Optional build macro: MAZE_STEP_COUNT_EN adds a saturating step_count
// output (pushes + pops of the current solve).
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   start               begin a solve (accepted in IDLE/DONE/FAIL only)
//   mem_rd/mem_addr     cell probe request, address {Y,X}
//   mem_valid/mem_wall  probe response; mem_wall=1 means blocked
//   X, Y                current position
//   busy, done, fail    solve status
//   path_len            moves in solved path (DONE only)
//   rd_en               advance readout pointer
//   move, move_valid    current readout move
//   step_count          (MAZE_STEP_COUNT_EN only) push/pop count
module maze_dfs_engine #(
  parameter int N     = 4,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  output logic           mem_rd,
  output logic [2*N-1:0] mem_addr,
  input  logic           mem_valid,
  input  logic           mem_wall,
  output logic [N-1:0]   X,
  output logic [N-1:0]   Y,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic [AW:0]    path_len,
  input  logic           rd_en,
  output logic [1:0]     move,
  output logic           move_valid
`ifdef MAZE_STEP_COUNT_EN
  ,
  output logic [15:0]    step_count
`endif
);

  localparam int          CELLS   = 1 << (2 * N);
  localparam logic [AW:0] SP_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW + 1)'(1);
  localparam logic [N-1:0] EDGE   = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PROBE, S_WAIT, S_MOVE, S_NEXT, S_BACK, S_DONE, S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     x_q, x_d, y_q, y_d;
  logic [1:0]       dir_q, dir_d;
  logic [AW:0]      sp_q, sp_d, rdptr_q, rdptr_d;
  logic [CELLS-1:0] vis_q, vis_d;
  logic [2*N-1:0]   addr_q, addr_d;
  logic [1:0]       stack_q [DEPTH];
  logic             push_en;

  logic [N-1:0]     nx, ny;
  logic             oob;
  logic [AW-1:0]    sp_dec;
  logic [1:0]       top;
  logic             rd_ok;

  // Neighbour of the current cell in direction dir_q; oob flags a carry or
  // borrow out of the N-bit coordinate.
  always_comb begin
    nx  = x_q;
    ny  = y_q;
    oob = 1'b0;
    case (dir_q)
      2'd0: begin oob = (x_q == EDGE); nx = x_q + N'(1); end
      2'd1: begin oob = (y_q == EDGE); ny = y_q + N'(1); end
      2'd2: begin oob = (x_q == '0);   nx = x_q - N'(1); end
      default: begin oob = (y_q == '0); ny = y_q - N'(1); end
    endcase
  end

  assign sp_dec = sp_q[AW-1:0] - AW'(1);
  assign top    = stack_q[sp_dec];
  assign rd_ok  = (state_q == S_DONE) && (rdptr_q < sp_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    sp_d    = sp_q;
    rdptr_d = rdptr_q;
    vis_d   = vis_q;
    addr_d  = addr_q;
    push_en = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start) state_d = S_INIT;
      end
      S_DONE: begin
        if (start) state_d = S_INIT;
        else if (rd_en && rd_ok) rdptr_d = rdptr_q + SP_ONE;
      end
      S_INIT: begin
        x_d      = '0;
        y_d      = '0;
        sp_d     = '0;
        rdptr_d  = '0;
        dir_d    = '0;
        vis_d    = '0;
        vis_d[0] = 1'b1;
        state_d  = S_PROBE;
      end
      S_PROBE: begin
        if (oob || vis_q[{ny, nx}]) begin
          state_d = S_NEXT;
        end else begin
          addr_d  = {ny, nx};
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_valid) state_d = mem_wall ? S_NEXT : S_MOVE;
      end
      S_MOVE: begin
        // dir_q is unchanged since PROBE, so nx/ny still name the probed cell.
        if (sp_q == SP_FULL) begin
          state_d = S_FAIL;
        end else begin
          push_en          = 1'b1;
          sp_d             = sp_q + SP_ONE;
          x_d              = nx;
          y_d              = ny;
          vis_d[{ny, nx}]  = 1'b1;
          dir_d            = '0;
          state_d          = (nx == EDGE && ny == EDGE) ? S_DONE : S_PROBE;
        end
      end
      S_NEXT: begin
        if (dir_q == 2'd3) begin
          state_d = S_BACK;
        end else begin
          dir_d   = dir_q + 2'd1;
          state_d = S_PROBE;
        end
      end
      S_BACK: begin
        if (sp_q == '0) begin
          state_d = S_FAIL;
        end else begin
          sp_d = sp_q - SP_ONE;
          case (top)
            2'd0:    x_d = x_q - N'(1);
            2'd1:    y_d = y_q - N'(1);
            2'd2:    x_d = x_q + N'(1);
            default: y_d = y_q + N'(1);
          endcase
          // A popped direction of 3 has no successor; keep unwinding.
          if (top != 2'd3) begin
            dir_d   = top + 2'd1;
            state_d = S_PROBE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      sp_q    <= '0;
      rdptr_q <= '0;
      vis_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      sp_q    <= sp_d;
      rdptr_q <= rdptr_d;
      vis_q   <= vis_d;
      addr_q  <= addr_d;
    end
  end

  // Stack storage needs no reset: entries are only read below sp / path_len.
  always_ff @(posedge CLK) begin
    if (push_en) stack_q[sp_q[AW-1:0]] <= dir_q;
  end

  assign mem_rd     = (state_q == S_WAIT);
  assign mem_addr   = addr_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign done       = (state_q == S_DONE);
  assign fail       = (state_q == S_FAIL);
  assign path_len   = (state_q == S_DONE) ? sp_q : '0;
  assign move_valid = rd_ok;
  assign move       = rd_ok ? stack_q[rdptr_q[AW-1:0]] : 2'b00;

`ifdef MAZE_STEP_COUNT_EN
  logic [15:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if (state_q == S_INIT) begin
      steps_d = '0;
    end else if (((state_q == S_MOVE) && (sp_q != SP_FULL)) ||
                 ((state_q == S_BACK) && (sp_q != '0))) begin
      if (steps_q != '1) steps_d = steps_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) steps_q <= '0;
    else     steps_q <= steps_d;
  end

  assign step_count = steps_q;
`endif

endmodule

// File: tb/tb_maze_dfs_engine.sv
// Bench for maze_dfs_engine: N=2 main instance with a latency-configurable
// maze memory responder, plus a DEPTH=4 instance for stack overflow.
module tb_maze_dfs_engine;

  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           start = 1'b0;
  logic           mem_valid = 1'b0;
  logic           mem_wall = 1'b0;
  logic           rd_en = 1'b0;
  logic           mem_rd;
  logic [2*N-1:0] mem_addr;
  logic [N-1:0]   X, Y;
  logic           busy, done, fail;
  logic [AW:0]    path_len;
  logic [1:0]     move;
  logic           move_valid;

  logic           start2 = 1'b0;
  logic           mem_valid2 = 1'b0;
  logic           mem_wall2 = 1'b0;
  logic           rd_en2 = 1'b0;
  logic           mem_rd2;
  logic [3:0]     mem_addr2;
  logic [1:0]     X2, Y2;
  logic           busy2, done2, fail2;
  logic [2:0]     path_len2;
  logic [1:0]     move2;
  logic           move_valid2;
`ifdef MAZE_STEP_COUNT_EN
  logic [15:0]    step_count, step_count2;
`endif

  always #5 CLK = ~CLK;

  maze_dfs_engine #(.N(N), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_wall(mem_wall),
    .X(X), .Y(Y), .busy(busy), .done(done), .fail(fail), .path_len(path_len),
    .rd_en(rd_en), .move(move), .move_valid(move_valid)
`ifdef MAZE_STEP_COUNT_EN
    , .step_count(step_count)
`endif
  );

  maze_dfs_engine #(.N(2), .DEPTH(4)) u_ovf (
    .CLK(CLK), .RST(RST), .start(start2),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_valid(mem_valid2), .mem_wall(mem_wall2),
    .X(X2), .Y(Y2), .busy(busy2), .done(done2), .fail(fail2), .path_len(path_len2),
    .rd_en(rd_en2), .move(move2), .move_valid(move_valid2)
`ifdef MAZE_STEP_COUNT_EN
    , .step_count(step_count2)
`endif
  );

  typedef struct {
    int done_f;
    int fail_f;
    int x;
    int y;
    int plen;
    int steps;
  } res_t;

  int    vectors = 0;
  int    miscompares = 0;
  string cur_tag = "reset";

  int    probe_q[$];
  int    move_q[$];
  res_t  res_q[$];

  logic [15:0] maze = '0;
  int          lat_cfg = 0;
  bit          spur = 1'b0;

  int m_probes[$];
  int m_path[$];
  bit m_fail;
  int m_x, m_y, m_steps;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0d, required %0d", cur_tag, name, act, exp);
    end
  endtask

  // Reference: DFS on a 4x4 grid with integer coordinates and a queue for the
  // path. Neighbours tried in order +X, +Y, -X, -Y; backtracking resumes at
  // the direction after the one that led into the abandoned cell.
  task automatic ref_solve(input logic [15:0] walls, input int depth);
    bit vis[16];
    int x, y, d, nx, ny, pd;
    int dx[4];
    int dy[4];
    dx = '{1, 0, -1, 0};
    dy = '{0, 1, 0, -1};
    for (int i = 0; i < 16; i++) vis[i] = 1'b0;
    m_probes.delete();
    m_path.delete();
    m_fail = 1'b0;
    m_steps = 0;
    x = 0; y = 0; d = 0;
    vis[0] = 1'b1;
    for (int guard = 0; guard < 10000; guard++) begin
      if (d > 3) begin
        if (m_path.size() == 0) begin m_fail = 1'b1; break; end
        pd = m_path.pop_back();
        x = x - dx[pd];
        y = y - dy[pd];
        m_steps++;
        d = pd + 1;
        continue;
      end
      nx = x + dx[d];
      ny = y + dy[d];
      if (nx < 0 || nx > 3 || ny < 0 || ny > 3 || vis[ny*4+nx]) begin d++; continue; end
      m_probes.push_back(ny * 4 + nx);
      if (walls[ny*4+nx]) begin d++; continue; end
      if (m_path.size() == depth) begin m_fail = 1'b1; break; end
      m_path.push_back(d);
      x = nx; y = ny;
      vis[ny*4+nx] = 1'b1;
      m_steps++;
      d = 0;
      if (x == 3 && y == 3) break;
    end
    m_x = x;
    m_y = y;
  endtask

  task automatic prep(input logic [15:0] walls, input int lat, input bit sp);
    res_t r;
    maze = walls;
    lat_cfg = lat;
    spur = sp;
    ref_solve(walls, DEPTH);
    foreach (m_probes[i]) probe_q.push_back(m_probes[i]);
    if (!m_fail) foreach (m_path[i]) move_q.push_back(m_path[i]);
    r.done_f = m_fail ? 0 : 1;
    r.fail_f = m_fail ? 1 : 0;
    r.x = m_x;
    r.y = m_y;
    r.plen = m_fail ? 0 : m_path.size();
    r.steps = m_steps;
    res_q.push_back(r);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("reset outputs", int'({mem_rd, mem_addr, X, Y, busy, done, fail, path_len, move, move_valid}), 0);
    chk("reset outputs ovf", int'({mem_rd2, mem_addr2, X2, Y2, busy2, done2, fail2, path_len2, move2, move_valid2}), 0);
`ifdef MAZE_STEP_COUNT_EN
    chk("reset step_count", int'(step_count), 0);
`endif
    @(posedge CLK); #1 RST = 1'b0;
    probe_q.delete();
    move_q.delete();
    res_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [15:0] walls, input int lat, input bit sp);
    bit got;
    cur_tag = tag;
    prep(walls, lat, sp);
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (done || fail) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s/timeout: busy=%0d done=0 fail=0, required done or fail", tag, busy);
      do_reset();
      return;
    end
    for (int i = 0; i < 200 && move_q.size() > 0; i++) begin
      @(posedge CLK); #1 rd_en = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1 rd_en = 1'b1;
    end
    @(posedge CLK); #1 rd_en = 1'b0;
    @(negedge CLK);
    chk("moves left unread", move_q.size(), 0);
    chk("probes left unseen", probe_q.size(), 0);
    chk("move_valid after readout", int'(move_valid), 0);
    chk("done level held", int'(done), m_fail ? 0 : 1);
  endtask

  // Maze memory: answers lat_cfg cycles after mem_rd rises; optionally drives
  // stray mem_valid pulses while no probe is pending.
  int wait_cnt = 0;
  always @(negedge CLK) begin
    if (mem_rd) begin
      if (wait_cnt >= lat_cfg) begin
        mem_valid = 1'b1;
        mem_wall = maze[mem_addr];
        wait_cnt = 0;
      end else begin
        mem_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      mem_valid = spur && ($urandom_range(0, 3) == 0);
      mem_wall = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge CLK) mem_valid2 = mem_rd2;

  // Probe monitor: address order, stability and handshake length.
  bit prev_rd = 1'b0;
  int held_addr = 0;
  int run_len = 0;
  always @(negedge CLK) begin
    if (mem_rd && !prev_rd) begin
      if (probe_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s/probe: got probe of cell %0d, required no probe", cur_tag, mem_addr);
      end else begin
        chk("probe addr", int'(mem_addr), probe_q.pop_front());
      end
      held_addr = int'(mem_addr);
      run_len = 1;
    end else if (mem_rd) begin
      chk("probe addr stable", int'(mem_addr), held_addr);
      run_len++;
    end else if (prev_rd && !RST) begin
      chk("probe length", run_len, lat_cfg + 1);
    end
    prev_rd = mem_rd;
  end

  // Result and readout monitor.
  bit prev_df = 1'b0;
  always @(negedge CLK) begin
    res_t r;
    if ((done || fail) && !prev_df && !RST) begin
      if (res_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s/result: got done=%0d fail=%0d, required no result", cur_tag, done, fail);
      end else begin
        r = res_q.pop_front();
        chk("done", int'(done), r.done_f);
        chk("fail", int'(fail), r.fail_f);
        chk("busy", int'(busy), 0);
        chk("X", int'(X), r.x);
        chk("Y", int'(Y), r.y);
        chk("path_len", int'(path_len), r.plen);
        chk("move_valid at end", int'(move_valid), (r.done_f != 0 && r.plen > 0) ? 1 : 0);
`ifdef MAZE_STEP_COUNT_EN
        chk("step_count", int'(step_count), r.steps);
`endif
      end
    end
    prev_df = done || fail;
    if (done && move_valid && rd_en) begin
      if (move_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s/readout: got extra move %0d, required move_valid=0", cur_tag, move);
      end else begin
        chk("move", int'(move), move_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    bit got;

    repeat (2) @(negedge CLK);
    chk("reset outputs", int'({mem_rd, mem_addr, X, Y, busy, done, fail, path_len, move, move_valid}), 0);
    chk("reset outputs ovf", int'({mem_rd2, mem_addr2, X2, Y2, busy2, done2, fail2, path_len2, move2, move_valid2}), 0);
    @(posedge CLK); #1 RST = 1'b0;

    run_case("open", 16'h0000, 0, 1'b0);
    run_case("backtrack", 16'h0080, 0, 1'b0);
    run_case("unreachable", 16'h0012, 1, 1'b0);
    run_case("latency", 16'h0000, 3, 1'b0);

    cur_tag = "reset_in_wait";
    prep(16'h0000, 3, 1'b0);
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (mem_rd) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL reset_in_wait/mem_rd: got mem_rd=0, required 1 within 50 cycles");
    end
    do_reset();
    run_case("after_reset", 16'h0000, 1, 1'b0);

    cur_tag = "overflow";
    ref_solve(16'h0000, 4);
    @(posedge CLK); #1 start2 = 1'b1;
    @(posedge CLK); #1 start2 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (done2 || fail2) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL overflow/timeout: done2=0 fail2=0, required fail2=1");
    end
    chk("fail", int'(fail2), m_fail ? 1 : 0);
    chk("done", int'(done2), m_fail ? 0 : 1);
    chk("X", int'(X2), m_x);
    chk("Y", int'(Y2), m_y);
    chk("path_len", int'(path_len2), 0);
    chk("move_valid", int'(move_valid2), 0);
`ifdef MAZE_STEP_COUNT_EN
    chk("step_count", int'(step_count2), m_steps);
`endif

    for (int t = 0; t < 30; t++) begin
      w = 16'($urandom() & $urandom());
      run_case($sformatf("random%0d", t), w, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
